// File: rtl/sram_like_arbiter.sv
// N-to-1 arbiter for sram-like buses: combinational grant, request lock until accepted,
// and an in-order ID FIFO that routes responses back. Define ARB_RR_EN for round-robin selection.
module sram_like_arbiter #(
  parameter int NUM_CH          = 2,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_wr,
  input  logic [2*NUM_CH-1:0]          ch_size,
  input  logic [(DATA_W/8)*NUM_CH-1:0] ch_wstrb,
  input  logic [DATA_W*NUM_CH-1:0]     ch_addr,
  input  logic [DATA_W*NUM_CH-1:0]     ch_wdata,
  output logic [NUM_CH-1:0]            ch_addr_ok,
  output logic [NUM_CH-1:0]            ch_data_ok,
  output logic [DATA_W-1:0]            ch_rdata,
  output logic                         out_req,
  output logic                         out_wr,
  output logic [1:0]                   out_size,
  output logic [DATA_W/8-1:0]          out_wstrb,
  output logic [DATA_W-1:0]            out_addr,
  output logic [DATA_W-1:0]            out_wdata,
  input  logic                         out_addr_ok,
  input  logic                         out_data_ok,
  input  logic [DATA_W-1:0]            out_rdata,
  output logic                         err
);

  localparam int ID_W   = $clog2(NUM_CH);
  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = PTR_W + 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   lock_ch, lock_ch_next;
  logic [ID_W-1:0]   sel_ch, gnt_ch;
  logic [ID_W-1:0]   id_fifo [MAX_OUTSTANDING];
  logic [ID_W-1:0]   head_ch;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_full, fifo_empty;
  logic              push, pop;

  assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign head_ch    = id_fifo[rd_ptr];

`ifdef ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;

  // Search starts at rr_ptr; iterating downward lets the nearest requester win.
  always_comb begin
    int idx;
    idx    = 0;
    sel_ch = rr_ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (ch_req[idx]) sel_ch = ID_W'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      rr_ptr <= '0;
    else if (push)
      rr_ptr <= (gnt_ch == ID_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
  end
`else
  always_comb begin
    sel_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_req[i]) sel_ch = ID_W'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      lock_ch <= '0;
    end else begin
      state   <= state_next;
      lock_ch <= lock_ch_next;
    end
  end

  // A request left unaccepted is locked so its fields stay stable until the slave takes it.
  always_comb begin
    state_next   = state;
    lock_ch_next = lock_ch;
    gnt_ch       = sel_ch;
    out_req      = 1'b0;
    case (state)
      IDLE: begin
        out_req = (|ch_req) && !fifo_full;
        if (out_req && !out_addr_ok) begin
          state_next   = LOCKED;
          lock_ch_next = sel_ch;
        end
      end
      LOCKED: begin
        gnt_ch  = lock_ch;
        out_req = 1'b1;
        if (out_addr_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!resetn) out_req = 1'b0;
  end

  assign push = out_req && out_addr_ok;
  assign pop  = resetn && out_data_ok && !fifo_empty;

  always_comb begin
    out_wr     = 1'b0;
    out_size   = '0;
    out_wstrb  = '0;
    out_addr   = '0;
    out_wdata  = '0;
    ch_addr_ok = '0;
    ch_data_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_ch == ID_W'(i)) begin
        out_wr    = ch_wr[i];
        out_size  = ch_size[2*i +: 2];
        out_wstrb = ch_wstrb[STRB_W*i +: STRB_W];
        out_addr  = ch_addr[DATA_W*i +: DATA_W];
        out_wdata = ch_wdata[DATA_W*i +: DATA_W];
      end
      ch_addr_ok[i] = push && (gnt_ch == ID_W'(i));
      ch_data_ok[i] = pop && (head_ch == ID_W'(i));
    end
  end

  assign ch_rdata = out_rdata;

  always_ff @(posedge clk) begin
    if (push) id_fifo[wr_ptr] <= gnt_ch;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A response with nothing outstanding can't be routed; flag it until reset.
  always_ff @(posedge clk) begin
    if (!resetn)
      err <= 1'b0;
    else if (out_data_ok && fifo_empty)
      err <= 1'b1;
  end

endmodule
